// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver.
//
// Recovers frames of: start bit, DATA_WIDTH data bits (LSB first), optional
// parity bit, stop bit. The line is oversampled by a prescale factor
// (8, 16 or 32; anything else behaves as 8) that is latched, together with
// the parity settings, when a start bit is first seen.
//
// Optional feature:
//   UART_RX_MAJORITY_VOTE_EN  when defined, every bit is resolved by a 2-of-3
//                             vote over edges P/2-1, P/2 and P/2+1. Otherwise
//                             a single sample taken at edge P/2 is used.
//                             Resolve point and latency are the same either way.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   RX_IN          asynchronous serial line, idle high
//   prescale       oversampling factor (8/16/32)
//   parity_enable  1 = frame carries a parity bit
//   parity_type    0 = even, 1 = odd
//   P_DATA         last correctly received word
//   data_valid     one-cycle pulse for a good frame
//   parity_error   one-cycle pulse for a parity mismatch
//   stop_error     one-cycle pulse for a low stop bit
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic                  rx_p0;
    logic                  rx_p1;
    logic                  rx_s;
    logic [5:0]            p_lat;
    logic                  pe_lat;
    logic                  pt_lat;
    logic [5:0]            edge_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic [5:0]            half;
    logic [5:0]            edge_nxt;
    logic                  resolve_pt;
    logic                  last_edge;
    logic                  resolved;

    function automatic logic [5:0] decode_prescale(input logic [5:0] p);
        return (p == 6'd16 || p == 6'd32) ? p : 6'd8;
    endfunction

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w, input logic odd);
        return odd ? ~^w : ^w;
    endfunction

    // Stage p0/p1: two-flop synchronizer, reset to the idle (high) level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= RX_IN;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s       = rx_p1;
    assign half       = {1'b0, p_lat[5:1]};
    assign edge_nxt   = 6'(edge_cnt + 6'd1);
    assign resolve_pt = (edge_cnt == 6'(half + 6'd1));
    assign last_edge  = (edge_cnt == 6'(p_lat - 6'd1));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic smp_a;
    logic smp_b;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (edge_cnt == 6'(half - 6'd1)) smp_a <= rx_s;
        if (edge_cnt == half)            smp_b <= rx_s;
    end

    // Third vote is the live sample at the resolve edge itself
    assign resolved = maj3(smp_a, smp_b, rx_s);
`else
    logic smp;

    always_ff @(posedge clk) begin
        if (edge_cnt == half) smp <= rx_s;
    end

    assign resolved = smp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            p_lat        <= 6'd8;
            pe_lat       <= 1'b0;
            pt_lat       <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            par_bad      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            case (state)
                IDLE: begin
                    // The detecting cycle is edge 0 of the start bit
                    if (!rx_s) begin
                        p_lat    <= decode_prescale(prescale);
                        pe_lat   <= parity_enable;
                        pt_lat   <= parity_type;
                        edge_cnt <= 6'd1;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    edge_cnt <= last_edge ? 6'd0 : edge_nxt;
                    if (resolve_pt && resolved) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (last_edge) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    edge_cnt <= last_edge ? 6'd0 : edge_nxt;
                    if (resolve_pt) shreg <= {resolved, shreg[DATA_WIDTH-1:1]};
                    if (last_edge) begin
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= pe_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= BCW'(bit_cnt + 1'b1);
                        end
                    end
                end
                PARITY: begin
                    edge_cnt <= last_edge ? 6'd0 : edge_nxt;
                    if (resolve_pt) par_bad <= (resolved != parity_of(shreg, pt_lat));
                    if (last_edge) state <= STOP;
                end
                STOP: begin
                    edge_cnt <= last_edge ? 6'd0 : edge_nxt;
                    // Leave mid stop bit so a back-to-back start bit is caught
                    if (resolve_pt) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        if (!par_bad && resolved) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            parity_error <= par_bad;
                            stop_error   <= ~resolved;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// A directed table of frames with spec-derived expectations, hand sequences
// for glitch / reset / spike cases, and randomized frames checked against a
// frame-level reference model (expected pulse cycle, flags and word).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] p_data;
    logic       dv;
    logic       pe_o;
    logic       se_o;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (rx_in),
        .prescale     (prescale),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .P_DATA       (p_data),
        .data_valid   (dv),
        .parity_error (pe_o),
        .stop_error   (se_o)
    );

    typedef struct {
        int         c;
        bit         v;
        bit         pe;
        bit         se;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic [5:0] code;
        bit         pe;
        bit         pt;
        bit         pbit;
        bit         stopb;
        int         gap;
        bit         ev;
        bit         epe;
        bit         ese;
        int         eedge;
    } vec_t;

    ev_t        evq[$];
    vec_t       tbl[7];
    int         cyc;
    int         checks;
    int         errors;
    logic [7:0] exp_pdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of all outputs against the scoreboard
    task automatic monitor();
        logic [2:0] ep;
        ev_t        e;
        ep = 3'b000;
        if (rst) begin
            exp_pdata = 8'h00;
        end else begin
            if (evq.size() > 0 && evq[0].c == cyc) begin
                e  = evq.pop_front();
                ep = {e.v, e.pe, e.se};
                if (e.v) exp_pdata = e.d;
            end
            checks++;
            if ({dv, pe_o, se_o} !== ep) begin
                errors++;
                $display("FAIL pulses cycle %0d: got v/pe/se=%b required %b", cyc, {dv, pe_o, se_o}, ep);
            end
            checks++;
            if (p_data !== exp_pdata) begin
                errors++;
                $display("FAIL p_data cycle %0d: got %h required %h", cyc, p_data, exp_pdata);
            end
        end
    endtask

    task automatic tick(input logic line, input logic r);
        @(posedge clk);
        cyc++;
        #1;
        rx_in = line;
        rst   = r;
        @(negedge clk);
        monitor();
    endtask

    function automatic int eff_p(input logic [5:0] code);
        return (code == 6'd16) ? 16 : (code == 6'd32) ? 32 : 8;
    endfunction

    // Drives one frame; the expected outcome lands eedge cycles after edge 0,
    // which is two cycles after the line first goes low.
    task automatic send_frame(input logic [7:0] d, input logic [5:0] code,
                              input bit pe, input bit pt, input bit pbit,
                              input bit stopb, input int gap, input int spike,
                              input bit scramble, input bit ev, input bit epe,
                              input bit ese, input logic [7:0] ed, input int eedge);
        int p;
        int nb;
        int s;
        p  = eff_p(code);
        nb = 10 + (pe ? 1 : 0);
        s  = cyc + 1;
        prescale      = code;
        parity_enable = pe;
        parity_type   = pt;
        if (ev || epe || ese) evq.push_back('{s + 2 + eedge, ev, epe, ese, ed});
        for (int t = 0; t < nb * p + gap; t++) begin
            int   b;
            logic v;
            b = t / p;
            if (b == 0)                v = 1'b0;
            else if (b <= 8)           v = d[b-1];
            else if (pe && b == 9)     v = pbit;
            else if (b == nb - 1)      v = stopb;
            else                       v = 1'b1;
            if (t == spike) v = 1'b0;
            tick(v, 1'b0);
            if (scramble && t == 4) begin
                prescale      = 6'($urandom);
                parity_enable = 1'($urandom);
                parity_type   = 1'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] spike_exp;
        cyc = 0; checks = 0; errors = 0; exp_pdata = 8'h00;
        rst = 1'b1; rx_in = 1'b1;
        prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;

        // d, code, pe, pt, pbit, stop, gap, ev, epe, ese, edge
        tbl[0] = '{8'hA5, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b0, 78};
        tbl[1] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b0, 170};
        tbl[2] = '{8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b0, 170};
        tbl[3] = '{8'h55, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b1, 306};
        tbl[4] = '{8'h0F, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b0, 306};
        tbl[5] = '{8'hC3, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b0, 78};
        tbl[6] = '{8'h01, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b1, 86};

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("reset_p_data", 32'(p_data), 32'h0);
        chk("reset_data_valid", 32'(dv), 32'h0);
        chk("reset_parity_error", 32'(pe_o), 32'h0);
        chk("reset_stop_error", 32'(se_o), 32'h0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);

        for (int i = 0; i < 7; i++)
            send_frame(tbl[i].d, tbl[i].code, tbl[i].pe, tbl[i].pt, tbl[i].pbit,
                       tbl[i].stopb, tbl[i].gap, -1, 1'b0, tbl[i].ev, tbl[i].epe,
                       tbl[i].ese, tbl[i].d, tbl[i].eedge);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);

        // Start glitch: two low cycles at P=16, then a real frame
        prescale = 6'd16; parity_enable = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        send_frame(8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1, 1'b0,
                   1'b1, 1'b0, 1'b0, 8'h81, 154);

        // Back-to-back frames, then reset in the middle of a third
        send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0,
                   1'b1, 1'b0, 1'b0, 8'h12, 78);
        send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0,
                   1'b1, 1'b0, 1'b0, 8'h34, 78);
        for (int t = 0; t < 40; t++) begin
            logic [7:0] w;
            w = 8'h56;
            tick((t < 8) ? 1'b0 : w[(t / 8 - 1) % 8], 1'b0);
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("midrst_p_data", 32'(p_data), 32'h0);
        chk("midrst_pulses", 32'({dv, pe_o, se_o}), 32'h0);
        for (int i = 0; i < 120; i++) tick(1'b1, 1'b0);

        // One-cycle low spike at edge P/2 of data bit 3 (a 1)
`ifdef UART_RX_MAJORITY_VOTE_EN
        spike_exp = 8'hFF;
`else
        spike_exp = 8'hF7;
`endif
        send_frame(8'hFF, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4 * 16 + 8, 1'b0,
                   1'b1, 1'b0, 1'b0, spike_exp, 154);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            logic [5:0] code;
            logic [7:0] d;
            bit pe, pt, goodp, pbit, stopb, perr, serr;
            int p, gap, eedge;
            case ($urandom_range(0, 3))
                0:       code = 6'd8;
                1:       code = 6'd16;
                2:       code = 6'd32;
                default: code = 6'($urandom_range(0, 63));
            endcase
            p     = eff_p(code);
            d     = 8'($urandom);
            pe    = 1'($urandom);
            pt    = 1'($urandom);
            goodp = pt ? ~^d : ^d;
            pbit  = ($urandom_range(0, 4) == 0) ? ~goodp : goodp;
            stopb = ($urandom_range(0, 9) != 0);
            perr  = pe && (pbit != goodp);
            serr  = !stopb;
            eedge = (9 + (pe ? 1 : 0)) * p + p / 2 + 2;
            gap   = serr ? p + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            send_frame(d, code, pe, pt, pbit, stopb, gap, -1, stopb,
                       !perr && !serr, perr, serr, d, eedge);
        end

        for (int i = 0; i < 60; i++) tick(1'b1, 1'b0);
        chk("pending_events", 32'(evq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver and counterpart of the UART transmitter in the serial subsystem. It oversamples the `RX_IN` line by a run-time prescale factor and recovers frames of the form start bit, `DATA_WIDTH` data bits sent LSB first, an optional parity bit, and a stop bit. For each good frame it presents the parallel word with a one-cycle valid strobe. It flags parity and stop-bit errors and discards the data of any frame that has one.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame.
- `clk`  input  1  sole clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `RX_IN`  input  1  asynchronous serial line; idle level is high.
- `prescale`  input  6  oversampling factor; legal values are 8, 16 and 32; any other value is treated as 8.
- `parity_enable`  input  1  1 means the frame carries a parity bit.
- `parity_type`  input  1  0 is even parity, 1 is odd parity.
- `P_DATA`  output  DATA_WIDTH  last correctly received word.
- `data_valid`  output  1  one-cycle pulse when a good frame has been received.
- `parity_error`  output  1  one-cycle pulse when the received parity bit is wrong.
- `stop_error`  output  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `RX_IN` passes through a 2-flop synchronizer. All statements below refer to the synchronized signal `rx_s`.
- The block has two counters:
  - `edge_cnt` runs 0..P-1 within each bit, where P is the latched prescale.
  - `bit_cnt` counts data bits.
- State machine:
  - **IDLE**: when `rx_s` is 0, latch `prescale`, `parity_enable` and `parity_type`, set `edge_cnt` to 1, and go to START. That cycle counts as edge 0 of the start bit.
  - **START**: at the resolve point, a resolved 1 is a glitch and the block returns to IDLE with no outputs. A resolved 0 continues; at `edge_cnt` P-1 go to DATA.
  - **DATA**: resolve each bit and shift it in LSB first. After bit `DATA_WIDTH`-1 reaches edge P-1, go to PARITY if parity is enabled, otherwise go to STOP.
  - **PARITY**: at the resolve point, compare the resolved bit with the even or odd parity of the shifted word. At edge P-1 go to STOP.
  - **STOP**: at the resolve point, evaluate the frame and go to IDLE immediately, mid stop bit. This allows a back-to-back start bit to be detected.
- Frame evaluation, registered into the outputs on the next cycle:
  - No parity mismatch and stop bit = 1: `P_DATA` takes the word and `data_valid` pulses.
  - Otherwise `parity_error` and/or `stop_error` pulse, `P_DATA` holds its previous value, and `data_valid` stays 0.
- Changing `prescale` or parity settings mid-frame has no effect until the next frame starts.

## Timing
- Reset value of every output and counter is 0; the state is IDLE. Synchronizer flops reset to 1.
- Reset asserted mid-frame: the block is in IDLE on the next cycle, the partial frame is dropped and no pulses are generated.
- Resolve point of each bit is the cycle with `edge_cnt` = P/2+1.
- Input latency: a falling edge on `RX_IN` becomes START edge 0 two cycles later, through the synchronizer.
- Output latency: let k = 1 + `DATA_WIDTH` + `parity_enable`. The output pulse is high on edge k·P + P/2 + 2 counted from START edge 0, and lasts exactly one cycle.
  - Example: P=8, 8N1 gives the pulse on edge 78.
- Earliest next START edge 0 is the cycle after the frame is evaluated.
- A low `rx_s` during the STOP state before the resolve point is not treated as a start bit.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Each bit is sampled at edges P/2-1, P/2 and P/2+1.
  - The resolved value is the 2-of-3 majority, valid at the resolve point.
- Not defined:
  - A single sample is taken at edge P/2 and held to the resolve point.
  - Resolve point and latency are identical in both builds.

## Test plan
- Frame 0xA5, P=8, no parity, clean line -> `P_DATA`=0xA5 and `data_valid` high for 1 cycle on edge 78; no error pulses.
- Frame 0x3C, P=16, even parity enabled, correct parity bit 0 -> `P_DATA`=0x3C and `data_valid` pulses on edge 10·16+10 = 170.
- Frame 0x3C, P=16, odd parity enabled, line parity bit 0 -> `parity_error` pulses, `data_valid` stays 0, `P_DATA` keeps its prior value.
- Frame 0x55, P=32, stop bit driven low -> `stop_error` pulses on edge 9·32+18 = 306, no `data_valid`; then a following 0x0F frame is received correctly.
- Start glitch: `RX_IN` low for 2 cycles at P=16 -> return to IDLE, no output pulses; a frame 0x81 sent immediately after is received correctly.
- Back-to-back 0x12 and 0x34 at P=8 with no idle gap, plus `rst` pulsed mid-way through a third frame -> two `data_valid` pulses with the correct data, the third frame dropped, all outputs 0 after reset.
- With the macro: a 1-cycle low spike at edge P/2 of a 1 data bit -> the bit is received as 1. Without the macro: the same bit is received as 0.
